fir_out_buffer: RTL and testbench
=================================

// Module: fir_out_buffer
// PURPOSE
//  Downstream stage of the fir filter. Consumes data_out/out_enable strobes and decimates by DECIM.
//  Scales each kept sample by a right shift and saturates it to OUT_W bits.
//  Buffers results in a FWFT FIFO with a valid/ready output. Flags overflow and saturation.
// PARAMETERS
//  IN_W   16  width of fir data_out (unsigned)
//  OUT_W  8   output sample width
//  SHIFT  2   right-shift applied before saturation (0..IN_W-1)
//  DECIM  1   keep 1 of every DECIM accepted samples (>=1)
//  DEPTH  8   FIFO entries, power of two; AW = log2(DEPTH)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       async active-low reset (0 = reset, 1 = run)
//  in_data      in   IN_W    fir data_out
//  in_enable    in   1       fir out_enable; each high cycle = one sample
//  fir_error    in   1       fir error; while high, input is ignored
//  out_data     out  OUT_W   FIFO head, valid when out_valid
//  out_valid    out  1       FIFO not empty
//  out_ready    in   1       consumer accepts head this cycle
//  level        out  AW+1    FIFO occupancy, 0..DEPTH
//  overflow     out  1       sticky: a kept sample was dropped because the FIFO was full
//  saturated    out  1       sticky: a kept sample was clipped to all-ones
//  clear_status in   1       sync clear of overflow and saturated
// BEHAVIOUR
//  Reset (reset=0, async): pointers, level, decim counter -> 0; out_valid=0; out_data=0.
//   overflow and saturated -> 0. All FIFO contents are discarded, including mid-stream.
//  Accept: in_enable=1 && fir_error=0 at a clk edge.
//   If dcnt==DECIM-1 the sample is kept and dcnt<=0; otherwise dcnt<=dcnt+1 and the sample is dropped.
//   fir_error=1 holds dcnt.
//  Convert: s = in_data >> SHIFT. If s > 2^OUT_W-1 -> all ones and saturated<=1.
//  Push: a kept sample is written at the same edge. Latency is 1 cycle: out_valid rises after the next edge.
//  Empty FIFO with push and pop in the same cycle: not possible, because out_valid=0 at that edge.
//  Pop: out_valid && out_ready at an edge advances the read pointer.
//  Full FIFO with push and pop in the same cycle: push accepted, level unchanged, no overflow.
//  Full FIFO with push and no pop: sample dropped, overflow<=1, FIFO unchanged.
//  Sticky set and clear_status in the same cycle: set wins.
//  Pointers are AW bits and wrap modulo DEPTH. level is tracked as a separate counter.
//  Output data order is strictly FIFO.
// CONFIGURATION
//  FIR_OUT_ROUND_EN defined: round half-up before the shift, s = (in_data + (1<<(SHIFT-1))) >> SHIFT.
//   The add uses IN_W+1 bits, so it cannot wrap. No effect when SHIFT=0.
//  FIR_OUT_ROUND_EN undefined: plain truncation (s = in_data >> SHIFT).
// STRUCTURE
//  Shared header fir_defs.vh (package role) holds:
//   DECIM/SHIFT defaults and the IN_W=16 constant matching fir data_out.
//   The clog2 function used to derive AW.
//  Sub-module fir_out_fifo (DEPTH, OUT_W): FWFT storage, pointers and level.
//   push/pop/full/empty ports; it drops on full-without-pop.
//  Top level: decimation counter, scale/saturate logic, sticky flags.
// TESTING  (defaults unless stated; out_ready=1 unless stated)
//  1 Reset: fill 3 entries, pull reset=0 between edges.
//    -> out_valid, level, overflow, saturated all 0 immediately, with no clk edge.
//  2 Scale: in_data=30 -> out_data=7 one cycle later (8 with FIR_OUT_ROUND_EN).
//    in_data=16'h0400 -> out_data=8'hFF, saturated=1.
//  3 DECIM=3: strobes 4,8,12,16,20,24 -> exactly two outputs, 3 then 6.
//  4 Overflow: out_ready=0, 9 strobes of 4..36 step 4 -> level=8, overflow=1.
//    Then out_ready=1 drains 1,2,...,8 in order.
//  5 Full with push and pop in the same cycle -> level stays 8, overflow stays 0, head advances.
//  6 fir_error=1 with 4 strobes -> level and dcnt unchanged.
//    Then clear_status=1 for one cycle -> overflow=0, saturated=0.

Source files
------------

// File: rtl/fir_out_buffer_pkg.sv
// Shared constants, status record and clog2 helper for the fir output buffer.
// Optional build macro FIR_OUT_ROUND_EN is consumed by fir_out_buffer.sv.
package fir_out_buffer_pkg;

    localparam int FIR_IN_W      = 16;
    localparam int SHIFT_DEFAULT = 2;
    localparam int DECIM_DEFAULT = 1;

    typedef struct packed {
        logic overflow;
        logic saturated;
    } status_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO with a separate occupancy counter.
// A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
module fir_out_fifo
    import fir_out_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [OUT_W-1:0]       push_data,
    input  logic                   pop,
    output logic [OUT_W-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == (AW+1)'(DEPTH));
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        // Stale entries stay hidden once drained.
        head  = empty ? '0 : mem_q[rd_ptr_q];
        level = level_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/fir_out_buffer.sv
// Decimates, scales and saturates fir samples into a FWFT output FIFO.
// Define FIR_OUT_ROUND_EN to round half-up before the right shift.
module fir_out_buffer
    import fir_out_buffer_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = 8,
    parameter int SHIFT = SHIFT_DEFAULT,
    parameter int DECIM = DECIM_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_enable,
    input  logic                   fir_error,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [clog2(DEPTH):0]  level,
    output logic                   overflow,
    output logic                   saturated,
    input  logic                   clear_status
);

    localparam int              DW        = (DECIM > 1) ? clog2(DECIM) : 1;
    localparam logic [DW-1:0]   DCNT_LAST = DW'(DECIM - 1);
`ifdef FIR_OUT_ROUND_EN
    localparam logic [IN_W:0]   ROUND_ADD = (SHIFT > 0) ?
        ((IN_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

    logic [DW-1:0]    dcnt_q, dcnt_d;
    status_t          status_q, status_d;
    logic             accept, keep, clipped;
    logic [IN_W:0]    rounded, scaled;
    logic [OUT_W-1:0] sample;
    logic             fifo_full, fifo_empty, fifo_drop;

    always_comb begin
        accept = in_enable & ~fir_error;
        keep   = accept && (dcnt_q == DCNT_LAST);
        dcnt_d = dcnt_q;
        if (accept) begin
            dcnt_d = keep ? '0 : dcnt_q + DW'(1);
        end
    end

    // One extra bit of headroom so the rounding add cannot wrap.
    always_comb begin
`ifdef FIR_OUT_ROUND_EN
        rounded = {1'b0, in_data} + ROUND_ADD;
`else
        rounded = {1'b0, in_data};
`endif
        scaled  = rounded >> SHIFT;
        clipped = |(scaled >> OUT_W);
        sample  = clipped ? '1 : scaled[OUT_W-1:0];
    end

    always_comb begin
        fifo_drop          = keep & fifo_full & ~(out_ready & ~fifo_empty);
        status_d.overflow  = (status_q.overflow & ~clear_status) | fifo_drop;
        status_d.saturated = (status_q.saturated & ~clear_status) | (keep & clipped);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dcnt_q   <= '0;
            status_q <= '0;
        end else begin
            dcnt_q   <= dcnt_d;
            status_q <= status_d;
        end
    end

    fir_out_fifo #(
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (keep),
        .push_data (sample),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign out_valid = ~fifo_empty;
    assign overflow  = status_q.overflow;
    assign saturated = status_q.saturated;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed self-checking bench: a default instance plus a DECIM=3 instance.
module tb_fir_out_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_enable, fir_error, out_ready, clear_status;
    logic [7:0]  out_data;
    logic        out_valid, overflow, saturated;
    logic [3:0]  level;

    logic [15:0] in_data3;
    logic        in_enable3, fir_error3;
    logic [7:0]  out_data3;
    logic        out_valid3, overflow3, saturated3;
    logic [3:0]  level3;

    int compared   = 0;
    int mismatched = 0;
    int seen3      = 0;

`ifdef FIR_OUT_ROUND_EN
    localparam int EXP_30 = 8;
`else
    localparam int EXP_30 = 7;
`endif

    always #5 clk = ~clk;

    fir_out_buffer dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_enable(in_enable),
        .fir_error(fir_error), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .overflow(overflow),
        .saturated(saturated), .clear_status(clear_status)
    );

    fir_out_buffer #(.DECIM(3)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_enable(in_enable3),
        .fir_error(fir_error3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(1'b1), .level(level3), .overflow(overflow3),
        .saturated(saturated3), .clear_status(1'b0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle strobe; returns on the negedge after the sampling edge.
    task automatic applyStimulus(input logic [15:0] d);
        @(negedge clk);
        in_data   = d;
        in_enable = 1'b1;
        @(negedge clk);
        in_enable = 1'b0;
    endtask

    task automatic applyStimulus3(input logic [15:0] d);
        @(negedge clk);
        in_data3   = d;
        in_enable3 = 1'b1;
        @(negedge clk);
        in_enable3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp5 [8];
        exp5 = '{2, 3, 4, 5, 6, 7, 8, 10};
        reset = 1'b0;
        in_data = '0; in_enable = 1'b0; fir_error = 1'b0;
        out_ready = 1'b0; clear_status = 1'b0;
        in_data3 = '0; in_enable3 = 1'b0; fir_error3 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset mid-stream discards contents and flags without a clock edge
        applyStimulus(16'd4);
        applyStimulus(16'h0400);
        applyStimulus(16'd12);
        checkOutput("fill_level", level, 3);
        checkOutput("fill_sat", saturated, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_sat", saturated, 0);
        checkOutput("rst_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;

        // Scaling and saturation
        out_ready = 1'b1;
        applyStimulus(16'd30);
        checkOutput("scale_valid", out_valid, 1);
        checkOutput("scale_data", out_data, EXP_30);
        @(negedge clk);
        checkOutput("scale_popped", level, 0);
        applyStimulus(16'h0400);
        checkOutput("sat_data", out_data, 8'hFF);
        checkOutput("sat_flag", saturated, 1);
        @(negedge clk);

        // Overflow, with a clear colliding with the overflow set
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) applyStimulus(16'(4 * k));
        checkOutput("ovf_full_level", level, 8);
        checkOutput("ovf_before", overflow, 0);
        checkOutput("sat_sticky", saturated, 1);
        @(negedge clk);
        in_data = 16'd36; in_enable = 1'b1; clear_status = 1'b1;
        @(negedge clk);
        in_enable = 1'b0; clear_status = 1'b0;
        checkOutput("ovf_level", level, 8);
        checkOutput("ovf_set_wins", overflow, 1);
        checkOutput("sat_cleared", saturated, 0);
        @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        checkOutput("clr_overflow", overflow, 0);
        checkOutput("clr_sat", saturated, 0);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checkOutput("drain_order", out_data, k);
            @(negedge clk);
        end
        checkOutput("drain_empty", out_valid, 0);

        // Full FIFO with push and pop in the same cycle
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) applyStimulus(16'(4 * k));
        checkOutput("pp_full", level, 8);
        @(negedge clk);
        in_data = 16'd40; in_enable = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_enable = 1'b0;
        checkOutput("pp_level", level, 8);
        checkOutput("pp_overflow", overflow, 0);
        checkOutput("pp_head", out_data, 2);
        for (int i = 0; i < 8; i++) begin
            checkOutput("pp_drain", out_data, exp5[i]);
            @(negedge clk);
        end
        checkOutput("pp_empty", level, 0);

        // Decimation by 3: only every third accepted sample survives
        for (int i = 0; i < 6; i++) begin
            applyStimulus3(16'(4 * (i + 1)));
            seen3 += int'(out_valid3);
            if ((i % 3) == 2) checkOutput("dec_data", out_data3, (i + 1));
        end
        checkOutput("dec_count", seen3, 2);

        // fir_error freezes both the FIFO and the decimation counter
        out_ready = 1'b0;
        applyStimulus(16'd4);
        fir_error = 1'b1;
        repeat (4) applyStimulus(16'h0400);
        fir_error = 1'b0;
        checkOutput("err_level", level, 1);
        checkOutput("err_sat", saturated, 0);
        checkOutput("err_head", out_data, 1);

        applyStimulus3(16'd4);
        fir_error3 = 1'b1;
        repeat (4) applyStimulus3(16'h0400);
        fir_error3 = 1'b0;
        checkOutput("err3_valid", out_valid3, 0);
        applyStimulus3(16'd8);
        checkOutput("err3_dcnt_hold", out_valid3, 0);
        applyStimulus3(16'd12);
        checkOutput("err3_keep", out_valid3, 1);
        checkOutput("err3_data", out_data3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
